// File: rtl/rc4_prga_decrypt_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 keystream/decrypt stage:
//   - prga_state_t : states of the keystream-generation/decrypt FSM
//   - MSG_LEN_DEF / RD_LAT_DEF : default message length and memory read latency
//   - CHAR_SPACE / CHAR_LO / CHAR_HI : accepted plaintext character set
//     (space plus lowercase a..z), used when the character check is enabled
// ---------------------------------------------------------------------------
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;
    localparam int RD_LAT_DEF  = 2;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        RD_J = 3'd2,
        WR_I = 3'd3,
        WR_J = 3'd4,
        RD_F = 3'd5,
        WR_D = 3'd6,
        DONE = 3'd7
    } prga_state_t;

    // States that hold an address and wait for memory q.
    function automatic logic is_read_state(input prga_state_t s);
        return (s == RD_I) || (s == RD_J) || (s == RD_F);
    endfunction

    // Plaintext byte is a space or a lowercase letter.
    function automatic logic is_text_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// ---------------------------------------------------------------------------
// rc4_prga_decrypt_if
// Bundles the control handshake and the three memory ports of the RC4
// keystream/decrypt stage.
//   master : the decrypt FSM (drives addresses, write data, status)
//   slave  : sequencer + memories (drives start, s_q, rom_q)
// Signals:
//   start        sequencer -> FSM  one-cycle start pulse
//   finish       FSM -> seq        high while the FSM sits in DONE
//   fail         FSM -> seq        character-check abort flag
//   mem_req      FSM -> handler    S-memory port request
//   s_address/s_data/s_wren/s_q    S-memory port (256 x 8)
//   rom_address/rom_q              encrypted-message ROM
//   d_address/d_data/d_wren        decrypted-message RAM
// ---------------------------------------------------------------------------
interface rc4_prga_decrypt_if
    import rc4_pkg::*;
#(
    parameter int ADDR_W = $clog2(MSG_LEN_DEF)
);
    logic              start;
    logic              finish;
    logic              fail;
    logic              mem_req;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [ADDR_W-1:0] d_address;
    logic [7:0]        d_data;
    logic              d_wren;

    modport master (
        input  start, s_q, rom_q,
        output finish, fail, mem_req,
               s_address, s_data, s_wren,
               rom_address,
               d_address, d_data, d_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  finish, fail, mem_req,
               s_address, s_data, s_wren,
               rom_address,
               d_address, d_data, d_wren
    );
endinterface

// File: rtl/rc4_prga_decrypt_rd_wait_timer.sv
// ---------------------------------------------------------------------------
// rd_wait_timer
// Counts out the memory read latency for a read state. Loaded with RD_LAT-1
// on entry to a read state; o_sample is high during the cycle whose closing
// edge is the one at which memory q is valid.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   i_load    entering a read state this edge
//   i_active  currently in a read state
//   o_sample  sample memory q at the end of this cycle
// ---------------------------------------------------------------------------
module rd_wait_timer #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_active,
    output logic o_sample
);
    localparam int         CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(RD_LAT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_sample = i_active && (r_cnt == '0);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// ---------------------------------------------------------------------------
// rc4_prga_decrypt
// RC4 keystream generation plus decrypt. After the S-box has been shuffled,
// a start pulse runs MSG_LEN iterations of the RC4 PRGA over the shared
// S-memory, XORs each keystream byte with the encrypted ROM and writes the
// plaintext to the decrypted RAM.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      rc4_prga_decrypt_if.master (start/finish/fail, mem_req,
//            S-memory, ROM and decrypted-RAM ports)
// Parameters: MSG_LEN (bytes per run), RD_LAT (read latency in cycles),
//             ADDR_W (ROM/RAM address width).
// Build option: define RC4_CHAR_CHECK_EN to abort the run (fail=1, no RAM
// write) on the first plaintext byte that is not a space or a..z.
// ---------------------------------------------------------------------------
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int ADDR_W  = $clog2(MSG_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rc4_prga_decrypt_if.master   bus
);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

    prga_state_t       r_state;
    prga_state_t       w_state_next;

    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [ADDR_W-1:0] r_k;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [7:0]        r_f;
    logic [7:0]        r_enc;

    logic              w_start_accept;
    logic              w_sample;
    logic              w_rd_active;
    logic              w_rd_load;
    logic              w_last;
    logic [7:0]        w_pt;

    assign w_pt        = r_f ^ r_enc;
    assign w_last      = (r_k == LAST_K);
    assign w_rd_active = is_read_state(r_state);
    // Restart the latency count whenever a read state is entered, including
    // the direct RD_I -> RD_J hand-over.
    assign w_rd_load   = is_read_state(w_state_next) && (w_state_next != r_state);

    rd_wait_timer #(
        .RD_LAT (RD_LAT)
    ) u_rd_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_rd_load),
        .i_active (w_rd_active),
        .o_sample (w_sample)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and memory-port outputs
    // -----------------------------------------------------------------------
`ifdef RC4_CHAR_CHECK_EN
    logic w_abort;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_start_accept  = 1'b0;
`ifdef RC4_CHAR_CHECK_EN
        w_abort         = 1'b0;
`endif
        bus.finish      = 1'b0;
        bus.mem_req     = 1'b0;
        bus.s_address   = '0;
        bus.s_data      = '0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.d_address   = '0;
        bus.d_data      = '0;
        bus.d_wren      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = RD_I;
                end
            end

            RD_I: begin
                bus.mem_req   = 1'b1;
                bus.s_address = r_i;
                if (w_sample) begin
                    w_state_next = RD_J;
                end
            end

            RD_J: begin
                bus.mem_req   = 1'b1;
                bus.s_address = r_j;
                if (w_sample) begin
                    w_state_next = WR_I;
                end
            end

            WR_I: begin
                bus.mem_req   = 1'b1;
                bus.s_address = r_i;
                bus.s_data    = r_sj;
                bus.s_wren    = 1'b1;
                w_state_next  = WR_J;
            end

            // When i == j both writes hit the same address with the same
            // value, which is exactly the RC4 swap result.
            WR_J: begin
                bus.mem_req   = 1'b1;
                bus.s_address = r_j;
                bus.s_data    = r_si;
                bus.s_wren    = 1'b1;
                w_state_next  = RD_F;
            end

            RD_F: begin
                bus.mem_req     = 1'b1;
                bus.s_address   = r_si + r_sj;
                bus.rom_address = r_k;
                if (w_sample) begin
                    w_state_next = WR_D;
                end
            end

            WR_D: begin
                bus.mem_req   = 1'b1;
                bus.d_address = r_k;
                bus.d_data    = w_pt;
                bus.d_wren    = 1'b1;
`ifdef RC4_CHAR_CHECK_EN
                if (!is_text_char(w_pt)) begin
                    bus.d_wren   = 1'b0;
                    w_abort      = 1'b1;
                    w_state_next = DONE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RD_I;
                end
`else
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RD_I;
                end
`endif
            end

            DONE: begin
                bus.finish = 1'b1;
                if (bus.start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = RD_I;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: indices and sampled memory bytes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_si  <= '0;
            r_sj  <= '0;
            r_f   <= '0;
            r_enc <= '0;
        end else begin
            if (w_start_accept) begin
                r_i <= 8'd1;
                r_j <= 8'd0;
                r_k <= '0;
            end

            case (r_state)
                RD_I: begin
                    if (w_sample) begin
                        r_si <= bus.s_q;
                        r_j  <= r_j + bus.s_q;
                    end
                end
                RD_J: begin
                    if (w_sample) begin
                        r_sj <= bus.s_q;
                    end
                end
                RD_F: begin
                    if (w_sample) begin
                        r_f   <= bus.s_q;
                        r_enc <= bus.rom_q;
                    end
                end
                WR_D: begin
                    if (!w_last) begin
                        r_k <= r_k + ADDR_W'(1);
                        r_i <= r_i + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Character-check abort flag
    // -----------------------------------------------------------------------
`ifdef RC4_CHAR_CHECK_EN
    logic r_fail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fail <= 1'b0;
        end else if (w_start_accept) begin
            r_fail <= 1'b0;
        end else if (w_abort) begin
            r_fail <= 1'b1;
        end
    end

    assign bus.fail = r_fail;
`else
    assign bus.fail = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// ---------------------------------------------------------------------------
// tb_rc4_prga_decrypt
// Bench for rc4_prga_decrypt with behavioural S-memory, ROM and RAM models.
// Expected plaintext bytes come from a reference RC4 keystream model and are
// queued at start; each RAM write from the DUT is popped and compared.
// Honours RC4_CHAR_CHECK_EN for the character-check scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc4_prga_decrypt;

    localparam int MSG_LEN  = 32;
    localparam int ADDR_W   = 5;
    localparam int RD_LAT   = 2;
    localparam int BYTE_CYC = 3 * RD_LAT + 3;
    localparam int RUN_CYC  = MSG_LEN * BYTE_CYC;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rc4_prga_decrypt_if #(.ADDR_W(ADDR_W)) bus();

    rc4_prga_decrypt #(
        .MSG_LEN (MSG_LEN),
        .RD_LAT  (RD_LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory models: registered-read single-port style.
    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [MSG_LEN];
    logic [7:0] ram_mem [MSG_LEN];
    logic [7:0] s_model [256];
    logic [7:0] ks      [MSG_LEN];
    logic [7:0] pt      [MSG_LEN];

    always @(posedge clk) begin
        bus.s_q   <= s_mem[bus.s_address];
        bus.rom_q <= rom_mem[bus.rom_address];
        if (bus.s_wren) s_mem[bus.s_address] = bus.s_data;
        if (bus.d_wren) ram_mem[bus.d_address] = bus.d_data;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard of expected {address, plaintext} writes.
    logic [15:0] sb_q[$];
    int  n_writes = 0;
    bit  chk_swap = 1'b0;

    always @(negedge clk) begin
        if (reset_n && bus.d_wren) begin
            logic [15:0] exp_w;
            n_writes++;
            $display("wr  addr=%0d data=%02h", bus.d_address, bus.d_data);
            check_eq("wr_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                check_eq("wr_addr_data", {8'(bus.d_address), bus.d_data}, exp_w);
            end
            if (chk_swap && bus.d_address == ADDR_W'(1)) begin
                check_eq("swap_s2", s_mem[2], 8'd3);
                check_eq("swap_s3", s_mem[3], 8'd2);
            end
        end
    end

    function automatic logic [63:0] out_vec();
        return {25'd0, bus.finish, bus.fail, bus.mem_req, bus.s_address, bus.s_data,
                bus.s_wren, bus.rom_address, bus.d_address, bus.d_data, bus.d_wren};
    endfunction

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    endtask

    task automatic clear_mems();
        for (int x = 0; x < MSG_LEN; x++) begin
            rom_mem[x] = 8'h00;
            ram_mem[x] = 8'hEE;
        end
    endtask

    task automatic load_ksa(input logic [23:0] key);
        logic [7:0] j, t, kb;
        load_identity();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            case (x % 3)
                0: kb = key[23:16];
                1: kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + s_mem[x] + kb;
            t = s_mem[x];
            s_mem[x] = s_mem[j];
            s_mem[j] = t;
        end
    endtask

    // Reference RC4 PRGA over a copy of the current S-memory.
    task automatic compute_ks();
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) s_model[x] = s_mem[x];
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1;
            j = j + s_model[i];
            t = s_model[i];
            s_model[i] = s_model[j];
            s_model[j] = t;
            t = s_model[i] + s_model[j];
            ks[k] = s_model[t];
        end
    endtask

    task automatic push_expected(input int n);
        for (int k = 0; k < n; k++) sb_q.push_back({8'(k), ks[k] ^ rom_mem[k]});
    endtask

    // Start a run and count cycles from the accepting edge until finish.
    task automatic run(input int hold, input int glitch_at, output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        if (hold <= 1) bus.start = 1'b0;
        while (!bus.finish && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == hold - 1) bus.start = 1'b0;
            if (glitch_at > 0 && cyc == glitch_at) bus.start = 1'b1;
            if (glitch_at > 0 && cyc == glitch_at + 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int cyc;
        int exp_n;
        bus.start = 1'b0;
        clear_mems();
        load_identity();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", out_vec(), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_outputs", out_vec(), 64'd0);

        // 1: identity S, ROM zero
        clear_mems();
        load_identity();
        compute_ks();
        push_expected(MSG_LEN);
        run(1, 0, cyc);
        check_eq("t1_cycles", cyc, RUN_CYC);
        check_eq("t1_ram0", ram_mem[0], 8'h02);
        check_eq("t1_ram1", ram_mem[1], 8'h05);
        check_eq("t1_ram2", ram_mem[2], 8'h07);
        check_eq("t1_fail", bus.fail, 1'b0);
        check_eq("t1_memreq_done", bus.mem_req, 1'b0);
        check_eq("t1_sb_drain", sb_q.size(), 0);

        // 2: identity S, ROM 63/64/66, swap check after byte 1
        clear_mems();
        load_identity();
        rom_mem[0] = 8'h63;
        rom_mem[1] = 8'h64;
        rom_mem[2] = 8'h66;
        compute_ks();
        push_expected(MSG_LEN);
        chk_swap = 1'b1;
        run(1, 0, cyc);
        chk_swap = 1'b0;
        check_eq("t2_cycles", cyc, RUN_CYC);
        for (int k = 0; k < 3; k++) check_eq("t2_ram_a", ram_mem[k], 8'h61);
        check_eq("t2_sb_drain", sb_q.size(), 0);

        // 3: KSA-shuffled S for key 000249, matching ciphertext
        clear_mems();
        load_ksa(24'h000249);
        compute_ks();
        for (int k = 0; k < MSG_LEN; k++) begin
            pt[k] = 8'h61 + 8'((k * 7 + 3) % 26);
            rom_mem[k] = ks[k] ^ pt[k];
        end
        push_expected(MSG_LEN);
        run(1, 0, cyc);
        check_eq("t3_cycles", cyc, RUN_CYC);
        for (int k = 0; k < MSG_LEN; k++) check_eq("t3_plain", ram_mem[k], pt[k]);
        check_eq("t3_sb_drain", sb_q.size(), 0);

        // 4: reset at cycle 100 of a run, then a clean run
        clear_mems();
        load_identity();
        compute_ks();
        push_expected(MSG_LEN);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t4_async_reset", out_vec(), 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_idle_after_reset", out_vec(), 64'd0);
        clear_mems();
        load_identity();
        compute_ks();
        push_expected(MSG_LEN);
        run(1, 0, cyc);
        check_eq("t4_cycles", cyc, RUN_CYC);
        check_eq("t4_ram0", ram_mem[0], 8'h02);
        check_eq("t4_sb_drain", sb_q.size(), 0);

        // 5a: start pulse during RD_J is ignored
        clear_mems();
        load_identity();
        compute_ks();
        push_expected(MSG_LEN);
        n_writes = 0;
        run(1, 2, cyc);
        check_eq("t5_glitch_cycles", cyc, RUN_CYC);
        check_eq("t5_glitch_writes", n_writes, MSG_LEN);
        check_eq("t5_sb_drain", sb_q.size(), 0);

        // 5b: start held 3 cycles -> one run
        clear_mems();
        load_identity();
        compute_ks();
        push_expected(MSG_LEN);
        n_writes = 0;
        run(3, 0, cyc);
        repeat (20) @(posedge clk);
        #1;
        check_eq("t5_hold_cycles", cyc, RUN_CYC);
        check_eq("t5_hold_writes", n_writes, MSG_LEN);
        check_eq("t5_hold_finish", bus.finish, 1'b1);
        check_eq("t5_hold_sb_drain", sb_q.size(), 0);

        // 6: byte 4 decrypts to 8'h41
        clear_mems();
        load_identity();
        compute_ks();
        for (int k = 0; k < MSG_LEN; k++) begin
            pt[k] = (k == 4) ? 8'h41 : 8'h61 + 8'(k % 26);
            rom_mem[k] = ks[k] ^ pt[k];
        end
`ifdef RC4_CHAR_CHECK_EN
        exp_n = 4;
        push_expected(exp_n);
        n_writes = 0;
        run(1, 0, cyc);
        check_eq("t6_cycles", cyc, 5 * BYTE_CYC);
        check_eq("t6_fail", bus.fail, 1'b1);
        check_eq("t6_finish", bus.finish, 1'b1);
        check_eq("t6_ram4_untouched", ram_mem[4], 8'hEE);
`else
        exp_n = MSG_LEN;
        push_expected(exp_n);
        n_writes = 0;
        run(1, 0, cyc);
        check_eq("t6_cycles", cyc, RUN_CYC);
        check_eq("t6_fail", bus.fail, 1'b0);
        check_eq("t6_ram4", ram_mem[4], 8'h41);
`endif
        check_eq("t6_writes", n_writes, exp_n);
        check_eq("t6_sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Third FSM of the RC4 pipeline (keystream generation plus decrypt), downstream of the S-memory init and shuffle FSMs.
- Runs after the shuffle completes and consumes the permuted S array through the shared memory handler's decrypt port.
- Generates MSG_LEN keystream bytes, swapping S entries as it goes.
- XORs each keystream byte with the encrypted-message ROM and writes the plaintext into the decrypted-message RAM.

Parameters:
- MSG_LEN, 32: number of message bytes processed per run.
- ADDR_W, 5: width of the ROM and decrypted-RAM address; equals clog2(MSG_LEN).
- RD_LAT, 2: cycles an address is held before the memory q is sampled. Covers the altsyncram registered address plus one.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse from the shuffle-done sequencer
- finish  out  1  high while in DONE; cleared on the next accepted start
- fail  out  1  character-check abort flag (see Optional Feature)
- mem_req  out  1  request to the memory handler for the S-memory port
- s_address  out  8  S-memory address
- s_data  out  8  S-memory write data
- s_wren  out  1  S-memory write enable
- s_q  in  8  S-memory read data
- rom_address  out  ADDR_W  encrypted ROM address
- rom_q  in  8  encrypted ROM data
- d_address  out  ADDR_W  decrypted RAM address
- d_data  out  8  decrypted RAM write data
- d_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All registers (i, j, k, si, sj, f, enc, wait counter) and every output are 0.
- Read-step timing: the address is held stable for RD_LAT cycles. s_q and rom_q are sampled at the clock edge ending the RD_LAT-th cycle.
- Write-step timing: a write lasts 1 cycle with wren=1. wren is 0 in every other state.
- Arithmetic: i, j and the f address are 8-bit and wrap modulo 256. k counts 0..MSG_LEN-1.
- States:
  - IDLE: on start, set i=1, j=0, k=0, clear finish and fail, set mem_req=1; go to RD_I. A start arriving in any other state is ignored.
  - RD_I: s_address=i. On sample, si<=s_q and j<=j+s_q; go to RD_J.
  - RD_J: s_address=j (the updated j). On sample, sj<=s_q; go to WR_I.
  - WR_I: s_address=i, s_data=sj, s_wren=1; go to WR_J.
  - WR_J: s_address=j, s_data=si, s_wren=1; go to RD_F.
  - RD_F: s_address=si+sj and rom_address=k, both reads in parallel. On sample, f<=s_q and enc<=rom_q; go to WR_D.
  - WR_D: d_address=k, d_data=f^enc, d_wren=1.
    - If k==MSG_LEN-1: go to DONE.
    - Otherwise: k<=k+1, i<=i+1, go to RD_I.
  - DONE: finish=1, mem_req=0. Stay until the next start, which is accepted exactly as from IDLE.
- Each byte takes 3*RD_LAT+3 cycles. For a start sampled at edge E0, finish is high after edge E0+MSG_LEN*(3*RD_LAT+3), i.e. E0+288 at defaults.
- mem_req is high from start acceptance until DONE is entered.
- Case i==j: both swap writes target the same address with the same value; this is correct, with no special handling.
- Reset mid-run abandons the run. S and RAM contents are not restored.

Optional Feature:
- Macro: RC4_CHAR_CHECK_EN.
- With the macro defined:
  - In WR_D, if f^enc is neither 8'h20 nor in 8'h61..8'h7A, set d_wren=0 and fail<=1, and go to DONE (finish=1).
  - fail holds until the next start.
- Without the macro: fail is tied 0 and all MSG_LEN bytes are written unconditionally.

Decomposition:
- Package rc4_pkg holds:
  - the prga_state_t enum (IDLE, RD_I, RD_J, WR_I, WR_J, RD_F, WR_D, DONE);
  - defaults MSG_LEN_DEF=32 and RD_LAT_DEF=2;
  - constants CHAR_SPACE=8'h20, CHAR_LO=8'h61, CHAR_HI=8'h7A.
- One sub-module, rd_wait_timer: loads RD_LAT-1 on entry to a read state and asserts sample when it reaches 0. The main FSM uses it in all three read states.

Test Plan:
- Identity S (S[x]=x), ROM all 0, start pulse -> RAM[0]=8'h02, RAM[1]=8'h05, RAM[2]=8'h07; finish rises exactly 288 cycles after start.
- Identity S, ROM[0..2]=8'h63,8'h64,8'h66 -> RAM[0..2]=8'h61,8'h61,8'h61. After byte 1, S[2]=3 and S[3]=2.
- S preloaded from a golden KSA model for key 24'h000249, ROM loaded with the matching ciphertext -> all 32 RAM bytes match the golden plaintext.
- Assert reset_n=0 at cycle 100 of a run -> all outputs 0 immediately and state IDLE; a fresh start completes correctly.
- Pulse start during RD_J -> ignored, and the run's outputs are unchanged versus the no-pulse run. Hold start for 3 cycles in IDLE -> exactly one run.
- With RC4_CHAR_CHECK_EN, byte 4 decrypts to 8'h41 -> RAM[4] not written, fail=1 and finish=1 on the following cycle. Without the macro, the full run completes with fail=0.
